hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RISC-V core. It produces the `load_hazard` and `branch_taken` controls that the ID/EX register consumes, and the PC and IF/ID write enables. It also freezes the pipeline while a data-memory access is outstanding and flags a sticky timeout error. Hazard decisions are combinational from the current cycle's stage contents. Wait tracking and performance counters are registered.

---
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: stage contents and dmem handshake in,
// pipeline enables, flush/bubble controls and perf counters out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             memread_ex;
    logic [4:0]       rd_ex;
    logic             branch_ex;
    logic             mem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             flush_if_id;
    logic             load_hazard;
    logic             branch_taken;
    logic             pipe_hold;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rs1_id, rs2_id, uses_rs1, uses_rs2,
        output memread_ex, rd_ex, branch_ex,
        output mem_req, dmem_ready,
        input  pc_write, if_id_write, flush_if_id,
        input  load_hazard, branch_taken, pipe_hold,
        input  mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  rs1_id, rs2_id, uses_rs1, uses_rs2,
        input  memread_ex, rd_ex, branch_ex,
        input  mem_req, dmem_ready,
        output pc_write, if_id_write, flush_if_id,
        output load_hazard, branch_taken, pipe_hold,
        output mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use bubbles, branch flushes, dmem wait
// freeze with sticky timeout, and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        ERR
    } state_t;

    localparam int WC_W = $clog2(TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WC_W-1:0]  wcnt;
    logic [WC_W-1:0]  wcnt_nxt;

    logic             rs1_hit;
    logic             rs2_hit;
    logic             lu;
    logic             mem_wait;
    logic             hold;

    logic             pc_write;
    logic             if_id_write;
    logic             flush_if_id;
    logic             load_hazard;
    logic             branch_taken;
    logic             pipe_hold;

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign rs1_hit  = bus.uses_rs1 && (bus.rs1_id == bus.rd_ex);
    assign rs2_hit  = bus.uses_rs2 && (bus.rs2_id == bus.rd_ex);
    assign lu       = bus.memread_ex && (bus.rd_ex != 5'd0)
                      && (rs1_hit || rs2_hit);
    assign mem_wait = bus.mem_req && !bus.dmem_ready;
    assign hold     = mem_wait || (state == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Dropping the wait (ready or request withdrawn) is checked before the
    // timeout compare so a completion on the last allowed cycle still wins.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        unique case (state)
            RUN: begin
                if (mem_wait) begin
                    state_nxt = HOLD;
                    wcnt_nxt  = '0;
                end
            end
            HOLD: begin
                if (!mem_wait) begin
                    state_nxt = RUN;
                end else if (wcnt == WC_LAST) begin
                    state_nxt = ERR;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = RUN;
                wcnt_nxt  = '0;
            end
        endcase
    end

    // A branch seen during a freeze is simply not acted on yet; EX still
    // holds it, so it is taken in the first unfrozen cycle.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        flush_if_id  = 1'b0;
        load_hazard  = 1'b0;
        branch_taken = 1'b0;
        pipe_hold    = 1'b0;
        if (rst) begin
            pc_write = 1'b0;
        end else if (hold) begin
            pipe_hold = 1'b1;
        end else if (bus.branch_ex) begin
            branch_taken = 1'b1;
            flush_if_id  = 1'b1;
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
        end else if (lu) begin
            load_hazard = 1'b1;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((pipe_hold || load_hazard) && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (branch_taken && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.flush_if_id  = flush_if_id;
    assign bus.load_hazard  = load_hazard;
    assign bus.branch_taken = branch_taken;
    assign bus.pipe_hold    = pipe_hold;
    assign bus.mem_timeout  = !rst && (state == ERR);
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_count  = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch priority, dmem wait,
// deferred branch, timeout/ERR, reset recovery and counter saturation.
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_ctrl #(
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd,
                         input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic br, input logic req, input logic rdy);
        bus.memread_ex = mr;
        bus.rd_ex      = rd;
        bus.rs1_id     = r1;
        bus.uses_rs1   = u1;
        bus.rs2_id     = r2;
        bus.uses_rs2   = u2;
        bus.branch_ex  = br;
        bus.mem_req    = req;
        bus.dmem_ready = rdy;
    endtask

    task automatic idle();
        drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // reset values
        step();
        #1;
        check("rst_pc_write", 32'(bus.pc_write), 0);
        check("rst_if_id_write", 32'(bus.if_id_write), 0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_stall", 32'(bus.stall_cycles), 0);
        check("post_rst_flush", 32'(bus.flush_count), 0);
        check("post_rst_timeout", 32'(bus.mem_timeout), 0);
        check("post_rst_pc_write", 32'(bus.pc_write), 1);
        check("post_rst_if_id_write", 32'(bus.if_id_write), 1);

        // load-use on rs1
        step();
        drive(1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 0);
        #1;
        check("lu_rs1_hazard", 32'(bus.load_hazard), 1);
        check("lu_rs1_pc_write", 32'(bus.pc_write), 0);
        check("lu_rs1_if_id_write", 32'(bus.if_id_write), 0);
        step();
        drive(1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0);
        #1;
        check("lu_stall_1", 32'(bus.stall_cycles), 1);
        check("lu_x0_hazard", 32'(bus.load_hazard), 0);
        check("lu_x0_pc_write", 32'(bus.pc_write), 1);
        step();
        drive(1, 5'd7, 5'd3, 1, 5'd7, 1, 0, 0, 0);
        #1;
        check("lu_rs2_hazard", 32'(bus.load_hazard), 1);
        step();
        drive(1, 5'd7, 5'd3, 1, 5'd7, 0, 0, 0, 0);
        #1;
        check("lu_rs2_unused", 32'(bus.load_hazard), 0);
        drive(0, 5'd7, 5'd7, 1, 5'd7, 1, 0, 0, 0);
        #1;
        check("lu_no_load", 32'(bus.load_hazard), 0);
        check("lu_stall_2", 32'(bus.stall_cycles), 2);

        // branch beats simultaneous load-use
        do_reset();
        step();
        drive(1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0, 0);
        #1;
        check("br_taken", 32'(bus.branch_taken), 1);
        check("br_flush", 32'(bus.flush_if_id), 1);
        check("br_pc_write", 32'(bus.pc_write), 1);
        check("br_if_id_write", 32'(bus.if_id_write), 1);
        check("br_lu_masked", 32'(bus.load_hazard), 0);
        step();
        idle();
        #1;
        check("br_flush_count", 32'(bus.flush_count), 1);
        check("br_stall_count", 32'(bus.stall_cycles), 0);
        check("br_idle_taken", 32'(bus.branch_taken), 0);

        // 3-cycle memory wait
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
            #1;
            check("mw_hold", 32'(bus.pipe_hold), 1);
            check("mw_pc_write", 32'(bus.pc_write), 0);
            check("mw_if_id_write", 32'(bus.if_id_write), 0);
        end
        step();
        drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1);
        #1;
        check("mw_ready_hold", 32'(bus.pipe_hold), 0);
        check("mw_ready_pc_write", 32'(bus.pc_write), 1);
        step();
        idle();
        #1;
        check("mw_stall_3", 32'(bus.stall_cycles), 3);
        check("mw_timeout", 32'(bus.mem_timeout), 0);
        check("mw_run_hold", 32'(bus.pipe_hold), 0);

        // branch deferred through a 2-cycle wait
        do_reset();
        for (int k = 0; k < 2; k++) begin
            step();
            drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0);
            #1;
            check("bh_taken", 32'(bus.branch_taken), 0);
            check("bh_flush", 32'(bus.flush_if_id), 0);
            check("bh_hold", 32'(bus.pipe_hold), 1);
        end
        step();
        drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1);
        #1;
        check("bh_end_taken", 32'(bus.branch_taken), 1);
        check("bh_end_hold", 32'(bus.pipe_hold), 0);
        step();
        idle();
        #1;
        check("bh_flush_count", 32'(bus.flush_count), 1);
        check("bh_stall_count", 32'(bus.stall_cycles), 2);

        // ready on the last allowed HOLD cycle wins over timeout
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
        end
        step();
        drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1);
        #1;
        check("rw_hold", 32'(bus.pipe_hold), 0);
        step();
        idle();
        #1;
        check("rw_timeout", 32'(bus.mem_timeout), 0);
        check("rw_stall_4", 32'(bus.stall_cycles), 4);

        // request withdrawn mid-HOLD returns to RUN
        for (int k = 0; k < 2; k++) begin
            step();
            drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
        end
        step();
        idle();
        #1;
        check("drop_hold", 32'(bus.pipe_hold), 0);
        check("drop_pc_write", 32'(bus.pc_write), 1);

        // timeout into ERR
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step();
            drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
            #1;
            check("to_pre_timeout", 32'(bus.mem_timeout), 0);
            check("to_pre_hold", 32'(bus.pipe_hold), 1);
        end
        step();
        #1;
        check("to_timeout", 32'(bus.mem_timeout), 1);
        check("to_stall_5", 32'(bus.stall_cycles), 5);
        drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1);
        #1;
        check("err_ready_hold", 32'(bus.pipe_hold), 1);
        check("err_ready_pc_write", 32'(bus.pc_write), 0);
        check("err_branch_masked", 32'(bus.branch_taken), 0);
        step();
        idle();
        #1;
        check("err_idle_hold", 32'(bus.pipe_hold), 1);
        check("err_sticky", 32'(bus.mem_timeout), 1);
        step();
        rst = 1'b1;
        #1;
        check("err_rst_hold", 32'(bus.pipe_hold), 0);
        check("err_rst_timeout", 32'(bus.mem_timeout), 0);
        step();
        rst = 1'b0;
        #1;
        check("err_clr_timeout", 32'(bus.mem_timeout), 0);
        check("err_clr_stall", 32'(bus.stall_cycles), 0);
        check("err_clr_flush", 32'(bus.flush_count), 0);
        check("err_clr_hold", 32'(bus.pipe_hold), 0);
        check("err_clr_pc_write", 32'(bus.pc_write), 1);

        // stall counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            drive(1, 5'd9, 5'd9, 1, 5'd0, 0, 0, 0, 0);
            #1;
            check("sat_hazard", 32'(bus.load_hazard), 1);
            if (i == 15) begin
                check("sat_reach_15", 32'(bus.stall_cycles), 15);
            end
        end
        step();
        idle();
        #1;
        check("sat_stall_15", 32'(bus.stall_cycles), 15);
        step();
        #1;
        check("sat_stall_hold", 32'(bus.stall_cycles), 15);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
